tb_run_monitor: RTL and testbench

Parametrised run-control monitor for the core-level testbenches. It watches pass/fail/exit signals and fetch addresses from NUM_CH cores. It also runs a cycle watchdog and a per-channel hang detector, then reports one registered verdict that the simulation top uses to end the run. Unlike the single-core top-level checks, it supports several channels, a first-event or wait-all completion mode, and hang detection, all from synthesizable logic.

---
 rtl/tb_run_monitor.sv | 255 +++++++++++++++++++++++++
 tb/tb_tb_run_monitor.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_monitor
// Description : Multi-channel run-control monitor. Watches pass/fail/exit
//               strobes and fetch addresses of NUM_CH cores, runs a cycle
//               watchdog and per-channel hang detectors, and produces one
//               registered, sticky verdict for the simulation top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_monitor #(
    parameter int  NUM_CH      = 1,
    parameter int  CYCLE_W     = 32,
    parameter int  STALL_LIMIT = 1024,
    parameter int  WAIT_ALL    = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [CYCLE_W-1:0]   max_cycles_i,
    input  logic [NUM_CH-1:0]    passed_i,
    input  logic [NUM_CH-1:0]    failed_i,
    input  logic [NUM_CH-1:0]    exit_valid_i,
    input  logic [NUM_CH*32-1:0] exit_value_i,
    input  logic [NUM_CH*32-1:0] instr_addr_i,
    output logic                 done_o,
    output logic [2:0]           status_o,
    output logic [CH_W-1:0]      chan_o,
    output logic [31:0]          exit_value_o,
    output logic [CYCLE_W-1:0]   cycle_cnt_o
);

    localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [2:0] c_stat_none     = 3'd0;
    localparam logic [2:0] c_stat_pass     = 3'd1;
    localparam logic [2:0] c_stat_fail     = 3'd2;
    localparam logic [2:0] c_stat_exit_ok  = 3'd3;
    localparam logic [2:0] c_stat_exit_err = 3'd4;
    localparam logic [2:0] c_stat_timeout  = 3'd5;
    localparam logic [2:0] c_stat_hang     = 3'd6;

    localparam logic [SW-1:0] c_stall_lim = SW'(STALL_LIMIT);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_run;
    logic                w_first;
    logic                w_timeout;

    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   w_mask_nxt;
    logic [NUM_CH-1:0]   w_active;
    logic [NUM_CH-1:0]   w_ev;
    logic [NUM_CH-1:0]   w_hang;
    logic [2:0]          w_code       [NUM_CH];
    logic [31:0]         w_xv_in      [NUM_CH];
    logic [2:0]          r_res        [NUM_CH];
    logic [31:0]         r_res_xv     [NUM_CH];
    logic [2:0]          w_res_nxt    [NUM_CH];
    logic [31:0]         w_res_xv_nxt [NUM_CH];

    logic                w_verdict;
    logic [2:0]          w_v_status;
    logic [CH_W-1:0]     w_v_chan;
    logic [31:0]         w_v_xv;
    logic [2:0]          w_agg;
    logic                w_any_fail;
    logic                w_any_err;
    logic                w_any_ok;

    logic                r_done;
    logic [2:0]          r_status;
    logic [CH_W-1:0]     r_chan;
    logic [31:0]         r_exit_val;
    logic [CYCLE_W-1:0]  r_cnt;

    assign w_run     = (r_state == c_st_run);
    // The counter only reads zero during the very first RUN cycle.
    assign w_first   = (r_cnt == '0);
    assign w_timeout = (max_cycles_i != '0) && (r_cnt >= max_cycles_i);

    // Per-channel event decode, done-mask bookkeeping and hang detection
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_xv_in[g]  = exit_value_i[32*g +: 32];
        assign w_code[g]   = failed_i[g]     ? c_stat_fail :
                             exit_valid_i[g] ? ((w_xv_in[g] == '0) ? c_stat_exit_ok : c_stat_exit_err) :
                             passed_i[g]     ? c_stat_pass : c_stat_none;
        assign w_active[g] = (WAIT_ALL == 0) || !r_mask[g];
        assign w_ev[g]     = w_run && w_active[g] && (w_code[g] != c_stat_none);
        assign w_mask_nxt[g]   = r_mask[g] | w_ev[g];
        assign w_res_nxt[g]    = w_ev[g] ? w_code[g]  : r_res[g];
        assign w_res_xv_nxt[g] = w_ev[g] ? w_xv_in[g] : r_res_xv[g];

        if (STALL_LIMIT > 0) begin : g_hang
            logic [31:0]   w_addr;
            logic [31:0]   r_last_addr;
            logic [SW-1:0] r_stall;
            logic [SW-1:0] w_stall_nxt;

            assign w_addr = instr_addr_i[32*g +: 32];

            // Count consecutive cycles with an unchanged fetch address (saturating)
            always_comb begin
                w_stall_nxt = '0;
                if (!w_first && (w_addr == r_last_addr)) begin
                    w_stall_nxt = (r_stall == c_stall_lim) ? r_stall : r_stall + 1'b1;
                end
            end

            // Track the previous fetch address and the stall count while running
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_last_addr <= '0;
                    r_stall     <= '0;
                end else if (w_run) begin
                    r_last_addr <= w_addr;
                    r_stall     <= w_stall_nxt;
                end
            end

            assign w_hang[g] = w_run && w_active[g] && (w_stall_nxt == c_stall_lim);
        end else begin : g_no_hang
            assign w_hang[g] = 1'b0;
        end
    end

    // Latch each channel's first result for wait-all completion
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mask <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_res[c]    <= c_stat_none;
                r_res_xv[c] <= '0;
            end
        end else if (w_run && (WAIT_ALL != 0)) begin
            r_mask <= w_mask_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                r_res[c]    <= w_res_nxt[c];
                r_res_xv[c] <= w_res_xv_nxt[c];
            end
        end
    end

    // Verdict selection: channel event/completion, then hang, then watchdog
    always_comb begin
        w_verdict  = 1'b0;
        w_v_status = c_stat_none;
        w_v_chan   = '0;
        w_v_xv     = '0;
        w_agg      = c_stat_pass;
        w_any_fail = 1'b0;
        w_any_err  = 1'b0;
        w_any_ok   = 1'b0;

        if (WAIT_ALL == 0) begin
            // Descending scan so the lowest-index channel overwrites last.
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (w_ev[c]) begin
                    w_verdict  = 1'b1;
                    w_v_status = w_code[c];
                    w_v_chan   = CH_W'(c);
                    w_v_xv     = ((w_code[c] == c_stat_exit_ok) || (w_code[c] == c_stat_exit_err))
                                 ? w_xv_in[c] : '0;
                end
            end
        end else if (w_run && (&w_mask_nxt)) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_res_nxt[c] == c_stat_fail)     w_any_fail = 1'b1;
                if (w_res_nxt[c] == c_stat_exit_err) w_any_err  = 1'b1;
                if (w_res_nxt[c] == c_stat_exit_ok)  w_any_ok   = 1'b1;
            end
            w_agg = w_any_fail ? c_stat_fail :
                    w_any_err  ? c_stat_exit_err :
                    w_any_ok   ? c_stat_exit_ok : c_stat_pass;
            w_verdict  = 1'b1;
            w_v_status = w_agg;
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (w_res_nxt[c] == w_agg) begin
                    w_v_chan = CH_W'(c);
                    w_v_xv   = ((w_agg == c_stat_exit_ok) || (w_agg == c_stat_exit_err))
                               ? w_res_xv_nxt[c] : '0;
                end
            end
        end

        // Any accepted channel event this cycle masks hang and watchdog.
        if (!w_verdict && w_run && !(|w_ev)) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (w_hang[c]) begin
                    w_verdict  = 1'b1;
                    w_v_status = c_stat_hang;
                    w_v_chan   = CH_W'(c);
                end
            end
            if (!w_verdict && w_timeout) begin
                w_verdict  = 1'b1;
                w_v_status = c_stat_timeout;
                w_v_chan   = '0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: IDLE -> RUN on enable, RUN -> DONE on verdict, DONE holds
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (enable_i)  w_state_nxt = c_st_run;
            c_st_run:  if (w_verdict) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Verdict register and saturating RUN cycle counter (frozen on the verdict edge)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_done     <= 1'b0;
            r_status   <= c_stat_none;
            r_chan     <= '0;
            r_exit_val <= '0;
            r_cnt      <= '0;
        end else if (w_run) begin
            if (w_verdict) begin
                r_done     <= 1'b1;
                r_status   <= w_v_status;
                r_chan     <= w_v_chan;
                r_exit_val <= w_v_xv;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign done_o       = r_done;
    assign status_o     = r_status;
    assign chan_o       = r_chan;
    assign exit_value_o = r_exit_val;
    assign cycle_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_tb_run_monitor
// Description : Self-checking bench for tb_run_monitor. Three instances:
//               A = 4 ch first-event with hang limit 8, B = 4 ch wait-all with
//               hang limit 8, C = 1 ch with hang detection disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tb_run_monitor;

    localparam int T      = 80;
    localparam int NTRIAL = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         r_rst;
    logic         r_en;
    logic [31:0]  r_max;
    logic [3:0]   r_pass;
    logic [3:0]   r_fail;
    logic [3:0]   r_xvld;
    logic [127:0] r_xval;
    logic [127:0] r_addr;
    logic [3:0]   r_frz;

    logic         w_done_a, w_done_b, w_done_c;
    logic [2:0]   w_st_a, w_st_b, w_st_c;
    logic [1:0]   w_ch_a, w_ch_b;
    logic [0:0]   w_ch_c;
    logic [31:0]  w_xv_a, w_xv_b, w_xv_c;
    logic [15:0]  w_cnt_a, w_cnt_b;
    logic [31:0]  w_cnt_c;

    int total = 0;
    int bad   = 0;

    logic [31:0] s_addr [T][4];
    logic [2:0]  s_ev   [T][4];
    logic [31:0] s_xv   [T][4];

    tb_run_monitor #(.NUM_CH(4), .CYCLE_W(16), .STALL_LIMIT(8), .WAIT_ALL(0)) u_dut_a (
        .clk_i(clk), .rst_i(r_rst), .enable_i(r_en), .max_cycles_i(r_max[15:0]),
        .passed_i(r_pass), .failed_i(r_fail), .exit_valid_i(r_xvld),
        .exit_value_i(r_xval), .instr_addr_i(r_addr),
        .done_o(w_done_a), .status_o(w_st_a), .chan_o(w_ch_a),
        .exit_value_o(w_xv_a), .cycle_cnt_o(w_cnt_a)
    );

    tb_run_monitor #(.NUM_CH(4), .CYCLE_W(16), .STALL_LIMIT(8), .WAIT_ALL(1)) u_dut_b (
        .clk_i(clk), .rst_i(r_rst), .enable_i(r_en), .max_cycles_i(r_max[15:0]),
        .passed_i(r_pass), .failed_i(r_fail), .exit_valid_i(r_xvld),
        .exit_value_i(r_xval), .instr_addr_i(r_addr),
        .done_o(w_done_b), .status_o(w_st_b), .chan_o(w_ch_b),
        .exit_value_o(w_xv_b), .cycle_cnt_o(w_cnt_b)
    );

    tb_run_monitor #(.NUM_CH(1), .CYCLE_W(32), .STALL_LIMIT(0), .WAIT_ALL(0)) u_dut_c (
        .clk_i(clk), .rst_i(r_rst), .enable_i(r_en), .max_cycles_i(r_max),
        .passed_i(r_pass[0]), .failed_i(r_fail[0]), .exit_valid_i(r_xvld[0]),
        .exit_value_i(r_xval[31:0]), .instr_addr_i(r_addr[31:0]),
        .done_o(w_done_c), .status_o(w_st_c), .chan_o(w_ch_c),
        .exit_value_o(w_xv_c), .cycle_cnt_o(w_cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_a(input string tag, input logic d, input logic [2:0] s,
                         input logic [1:0] ch, input logic [31:0] xv, input logic [31:0] cnt);
        chk({tag, "_a_done"}, 32'(w_done_a), 32'(d));
        chk({tag, "_a_status"}, 32'(w_st_a), 32'(s));
        chk({tag, "_a_chan"}, 32'(w_ch_a), 32'(ch));
        chk({tag, "_a_exitval"}, w_xv_a, xv);
        chk({tag, "_a_cnt"}, 32'(w_cnt_a), cnt);
    endtask

    task automatic exp_b(input string tag, input logic d, input logic [2:0] s,
                         input logic [1:0] ch, input logic [31:0] xv, input logic [31:0] cnt);
        chk({tag, "_b_done"}, 32'(w_done_b), 32'(d));
        chk({tag, "_b_status"}, 32'(w_st_b), 32'(s));
        chk({tag, "_b_chan"}, 32'(w_ch_b), 32'(ch));
        chk({tag, "_b_exitval"}, w_xv_b, xv);
        chk({tag, "_b_cnt"}, 32'(w_cnt_b), cnt);
    endtask

    task automatic exp_c(input string tag, input logic d, input logic [2:0] s,
                         input logic [31:0] xv, input logic [31:0] cnt);
        chk({tag, "_c_done"}, 32'(w_done_c), 32'(d));
        chk({tag, "_c_status"}, 32'(w_st_c), 32'(s));
        chk({tag, "_c_chan"}, 32'(w_ch_c), 32'd0);
        chk({tag, "_c_exitval"}, w_xv_c, xv);
        chk({tag, "_c_cnt"}, w_cnt_c, cnt);
    endtask

    // One clock edge; outputs are then read 1 time unit later, and unfrozen
    // fetch addresses advance for the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (!r_frz[c]) r_addr[32*c +: 32] = r_addr[32*c +: 32] + 32'd4;
        end
    endtask

    task automatic clr_ev();
        r_pass = '0;
        r_fail = '0;
        r_xvld = '0;
        r_xval = '0;
    endtask

    task automatic do_reset();
        clr_ev();
        r_en  = 1'b0;
        r_max = '0;
        r_frz = '0;
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
    endtask

    task automatic start_run();
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
    endtask

    function automatic logic [2:0] code_of(input logic [2:0] ev, input logic [31:0] xv);
        if (ev[2]) return 3'd2;
        if (ev[1]) return (xv == 32'd0) ? 3'd3 : 3'd4;
        if (ev[0]) return 3'd1;
        return 3'd0;
    endfunction

    function automatic int rank_of(input logic [2:0] code);
        case (code)
            3'd2:    return 4;
            3'd4:    return 3;
            3'd3:    return 2;
            3'd1:    return 1;
            default: return 0;
        endcase
    endfunction

    // Length of the current run of identical addresses ending at cycle t.
    function automatic int stall_of(input int c, input int t);
        int s;
        s = t;
        while (s > 0 && s_addr[s][c] == s_addr[s-1][c]) s--;
        return t - s;
    endfunction

    // Reference: walk the scenario cycle by cycle and return the verdict.
    task automatic model(input bit w, input int m, output int e_t, output logic [2:0] e_st,
                         output logic [1:0] e_ch, output logic [31:0] e_xv);
        bit          dm  [4];
        logic [2:0]  res [4];
        logic [31:0] rxv [4];
        bit          any;
        bit          all;
        logic [2:0]  code;
        int          best;
        e_t = -1; e_st = 3'd0; e_ch = 2'd0; e_xv = 32'd0;
        for (int c = 0; c < 4; c++) begin dm[c] = 0; res[c] = 3'd0; rxv[c] = 32'd0; end
        for (int t = 0; t < T; t++) begin
            any = 0;
            for (int c = 0; c < 4; c++) begin
                if (s_ev[t][c] != 3'd0 && (!w || !dm[c])) begin
                    code = code_of(s_ev[t][c], s_xv[t][c]);
                    if (!any && !w) begin
                        e_st = code;
                        e_ch = 2'(c);
                        e_xv = (code >= 3'd3) ? s_xv[t][c] : 32'd0;
                    end
                    any = 1;
                    if (w) begin dm[c] = 1; res[c] = code; rxv[c] = s_xv[t][c]; end
                end
            end
            if (any) begin
                if (!w) begin e_t = t; return; end
                all = dm[0] && dm[1] && dm[2] && dm[3];
                if (all) begin
                    best = 0;
                    for (int c = 0; c < 4; c++) if (rank_of(res[c]) > best) best = rank_of(res[c]);
                    for (int c = 3; c >= 0; c--) begin
                        if (rank_of(res[c]) == best) begin
                            e_st = res[c];
                            e_ch = 2'(c);
                            e_xv = (res[c] >= 3'd3) ? rxv[c] : 32'd0;
                        end
                    end
                    e_t = t;
                    return;
                end
                continue;
            end
            for (int c = 0; c < 4; c++) begin
                if (!(w && dm[c]) && stall_of(c, t) >= 8) begin
                    e_t = t; e_st = 3'd6; e_ch = 2'(c); e_xv = 32'd0;
                    return;
                end
            end
            if (m != 0 && t >= m) begin
                e_t = t; e_st = 3'd5; e_ch = 2'd0; e_xv = 32'd0;
                return;
            end
        end
    endtask

    initial begin
        int          m;
        int          ta, tb2;
        logic [2:0]  sa, sb;
        logic [1:0]  ca, cb;
        logic [31:0] xa, xb;
        logic [31:0] base;
        int          fz;
        int          r;

        r_rst = 1'b1; r_en = 1'b0; r_max = '0; r_addr = '0; r_frz = '0;
        clr_ev();
        tick();
        tick();
        r_rst = 1'b0;

        // Reset state
        exp_a("reset", 0, 3'd0, 2'd0, 32'd0, 0);
        exp_b("reset", 0, 3'd0, 2'd0, 32'd0, 0);
        exp_c("reset", 0, 3'd0, 32'd0, 0);

        // Single channel: enable at cycle 2, pass after 11 RUN edges
        tick();
        tick();
        chk("idle_cnt_c", w_cnt_c, 32'd0);
        start_run();
        repeat (11) tick();
        chk("pre_pass_done_c", 32'(w_done_c), 32'd0);
        chk("pre_pass_cnt_c", w_cnt_c, 32'd11);
        r_pass[0] = 1'b1;
        tick();
        r_pass = '0;
        exp_c("pass", 1, 3'd1, 32'd0, 11);
        tick();
        exp_c("sticky", 1, 3'd1, 32'd0, 11);

        // First-event: exit on ch3 and pass on ch1 together -> PASS on ch1
        do_reset();
        start_run();
        repeat (3) tick();
        r_xvld[3] = 1'b1; r_xval[96 +: 32] = 32'd5; r_pass[1] = 1'b1;
        tick();
        clr_ev();
        exp_a("lowest_wins", 1, 3'd1, 2'd1, 32'd0, 3);

        // Fail and pass on the same channel -> FAIL
        do_reset();
        start_run();
        repeat (2) tick();
        r_fail[1] = 1'b1; r_pass[1] = 1'b1;
        tick();
        clr_ev();
        exp_a("fail_over_pass", 1, 3'd2, 2'd1, 32'd0, 2);

        // Events on channels 2 and 0 together -> channel 0
        do_reset();
        start_run();
        tick();
        r_xvld[2] = 1'b1; r_xval[64 +: 32] = 32'd9; r_pass[0] = 1'b1;
        tick();
        clr_ev();
        exp_a("ch2_ch0", 1, 3'd1, 2'd0, 32'd0, 1);

        // Wait-all: staggered reports, a repeat fail on ch0 is ignored
        do_reset();
        start_run();
        tick();                                   // edge 1
        r_pass[0] = 1'b1; tick(); clr_ev();       // edge 2
        tick();                                   // edge 3
        r_pass[1] = 1'b1; tick(); clr_ev();       // edge 4
        r_fail[0] = 1'b1; tick(); clr_ev();       // edge 5
        r_pass[3] = 1'b1; tick(); clr_ev();       // edge 6
        chk("waitall_partial_done_b", 32'(w_done_b), 32'd0);
        tick();                                   // edge 7
        tick();                                   // edge 8
        chk("waitall_partial2_done_b", 32'(w_done_b), 32'd0);
        r_xvld[2] = 1'b1; r_xval[64 +: 32] = 32'd7;
        tick();                                   // edge 9: completion
        clr_ev();
        exp_b("waitall", 1, 3'd4, 2'd2, 32'd7, 8);

        // Watchdog: limit 20 -> TIMEOUT after 21 RUN edges
        do_reset();
        r_max = 32'd20;
        start_run();
        repeat (20) tick();
        chk("wdog_pre_done_c", 32'(w_done_c), 32'd0);
        tick();
        exp_c("wdog", 1, 3'd5, 32'd0, 20);

        // Watchdog disabled: no verdict within 1000 cycles
        do_reset();
        start_run();
        repeat (1000) tick();
        chk("wdog_off_done_c", 32'(w_done_c), 32'd0);
        chk("wdog_off_cnt_c", w_cnt_c, 32'd1000);

        // Hang: ch1 frozen from RUN entry -> HANG after 9 RUN edges
        do_reset();
        r_frz = 4'b0010;
        start_run();
        repeat (8) tick();
        chk("hang_pre_done_a", 32'(w_done_a), 32'd0);
        tick();
        exp_a("hang", 1, 3'd6, 2'd1, 32'd0, 8);

        // Hang restart: address change at stall 7
        do_reset();
        r_frz = 4'b0010;
        start_run();
        repeat (8) tick();
        chk("hang_rst_pre_done_a", 32'(w_done_a), 32'd0);
        r_addr[32 +: 32] = r_addr[32 +: 32] + 32'h100;
        repeat (8) tick();
        chk("hang_rst_mid_done_a", 32'(w_done_a), 32'd0);
        tick();
        exp_a("hang_restart", 1, 3'd6, 2'd1, 32'd0, 16);

        // Reset in DONE
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        r_frz = '0;
        exp_a("rst_in_done", 0, 3'd0, 2'd0, 32'd0, 0);

        // Reset mid-RUN, inputs ignored in IDLE, then a clean restart
        start_run();
        repeat (5) tick();
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        exp_a("rst_mid_run", 0, 3'd0, 2'd0, 32'd0, 0);
        r_pass = 4'hF;
        repeat (3) tick();
        r_pass = '0;
        exp_a("idle_ignores", 0, 3'd0, 2'd0, 32'd0, 0);
        start_run();
        repeat (3) tick();
        exp_a("restart", 0, 3'd0, 2'd0, 32'd0, 3);

        // Randomized scenarios against the reference model
        for (int tr = 0; tr < NTRIAL; tr++) begin
            for (int c = 0; c < 4; c++) begin
                base = $urandom & 32'hFFFF_FFF0;
                fz   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70)) : 999;
                for (int t = 0; t < T; t++) begin
                    if (t == 0)                                   s_addr[t][c] = base;
                    else if (t >= fz || $urandom_range(0, 3) == 0) s_addr[t][c] = s_addr[t-1][c];
                    else                                          s_addr[t][c] = s_addr[t-1][c] + 32'd4;
                    r = int'($urandom_range(0, 29));
                    s_ev[t][c] = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : (r == 2) ? 3'b100 :
                                 (r == 3) ? 3'($urandom_range(1, 7)) : 3'b000;
                    s_xv[t][c] = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 15));
                end
            end
            m = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 70));
            model(0, m, ta, sa, ca, xa);
            model(1, m, tb2, sb, cb, xb);

            do_reset();
            r_max = 32'(m);
            start_run();
            for (int t = 0; t < T; t++) begin
                for (int c = 0; c < 4; c++) begin
                    r_addr[32*c +: 32] = s_addr[t][c];
                    r_fail[c]          = s_ev[t][c][2];
                    r_xvld[c]          = s_ev[t][c][1];
                    r_pass[c]          = s_ev[t][c][0];
                    r_xval[32*c +: 32] = s_xv[t][c];
                end
                @(posedge clk);
                #1;
                chk("rnd_done_a", 32'(w_done_a), 32'(ta >= 0 && t >= ta));
                chk("rnd_done_b", 32'(w_done_b), 32'(tb2 >= 0 && t >= tb2));
            end
            clr_ev();
            if (ta >= 0) exp_a("rnd", 1, sa, ca, xa, 32'(ta));
            else         exp_a("rnd", 0, 3'd0, 2'd0, 32'd0, 32'(T));
            if (tb2 >= 0) exp_b("rnd", 1, sb, cb, xb, 32'(tb2));
            else          exp_b("rnd", 0, 3'd0, 2'd0, 32'd0, 32'(T));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
